// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, datapath widths and
// the opcode field position consumed by the control decoder.
package pkg_rv_core;

    localparam int XLEN_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 2;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: reset value, sequential advance and redirect load.
// A redirect has priority over the sequential increment.
module pc_reg
    import pkg_rv_core::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_inc,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_pc,
    output logic [XLEN-1:0] o_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC & ALIGN_MASK;
        end else if (i_load) begin
            r_pc <= i_load_pc & ALIGN_MASK;
        end else if (i_inc) begin
            r_pc <= r_pc + XLEN'(PC_INC);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory read, holds the word for
// decode, squashes wrong-path data after a redirect.
//
//   state | meaning
//   FETCH | issue a request at pc (suppressed while redirect_valid)
//   WAIT  | request outstanding; discard marks a response already squashed
//   HOLD  | instruction presented to decode until accepted or redirected
module instr_fetch_unit
    import pkg_rv_core::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             inst_valid,
    input  logic             dec_ready,
    output logic [XLEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_pc,
    output logic [OPC_W-1:0] inst_opcode,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             busy
);

    fetch_state_t    r_state;
    logic            r_discard;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;

    logic [XLEN-1:0] w_pc;
    logic            w_pc_inc;
    logic            w_capture;

    // Only a clean, non-squashed response advances the PC.
    assign w_capture = (r_state == WAIT) && imem_valid && !r_discard && !redirect_valid;
    assign w_pc_inc  = w_capture;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_pc_inc),
        .i_load    (redirect_valid),
        .i_load_pc (redirect_pc),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_discard <= 1'b0;
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (!redirect_valid) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        r_discard <= 1'b0;
                        if (w_capture) begin
                            r_inst    <= imem_rdata;
                            r_inst_pc <= w_pc;
                            r_state   <= HOLD;
                        end else begin
                            r_state <= FETCH;
                        end
                    end else if (redirect_valid) begin
                        r_discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid || dec_ready) begin
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == FETCH) && !redirect_valid && !rst;
    assign imem_addr   = w_pc;
    assign inst_valid  = (r_state == HOLD);
    assign busy        = (r_state == WAIT);
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
    assign inst_opcode = r_inst[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: variable-latency memory model,
// scoreboard of expected instructions checked on decode acceptance.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: RESET_PC = 0
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        dec_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [4:0]  inst_opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    // DUT 2: RESET_PC near the top of the address space
    logic        rst2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_valid2 = 1'b0;
    logic [31:0] imem_rdata2 = '0;
    logic        inst_valid2;
    logic        dec_ready2;
    logic [31:0] inst2;
    logic [31:0] inst_pc2;
    logic [4:0]  inst_opcode2;
    logic        busy2;

    instr_fetch_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .dec_ready      (dec_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_opcode    (inst_opcode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk            (clk),
        .rst            (rst2),
        .imem_req       (imem_req2),
        .imem_addr      (imem_addr2),
        .imem_valid     (imem_valid2),
        .imem_rdata     (imem_rdata2),
        .inst_valid     (inst_valid2),
        .dec_ready      (dec_ready2),
        .inst           (inst2),
        .inst_pc        (inst_pc2),
        .inst_opcode    (inst_opcode2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .busy           (busy2)
    );

    int n_pass   = 0;
    int n_checks = 0;
    int pops     = 0;

    exp_t sb[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return {a[24:0], 7'b0110011};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory model 1: request seen at negedge, response after mem_lat cycles.
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic        req_seen = 1'b0;
    logic [31:0] req_addr = '0;

    always @(negedge clk) begin
        req_seen = imem_req && !rst;
        req_addr = imem_addr;
        if (rst) begin
            sb.delete();
        end else begin
            if (redirect_valid) begin
                sb.delete();
            end else if (inst_valid && dec_ready) begin
                check("sb_avail", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    pops = pops + 1;
                    check("sb_inst", inst, e.inst);
                    check("sb_pc", inst_pc, e.pc);
                    check("sb_opcode", 32'(inst_opcode), 32'(e.inst[6:2]));
                end
            end
            if (imem_req) sb.push_back('{mem_word(imem_addr), imem_addr});
        end
    end

    always @(posedge clk) begin
        #1;
        imem_valid = 1'b0;
        if (rst) begin
            mem_cnt = 0;
        end else begin
            if (req_seen) begin
                mem_cnt  = mem_lat;
                mem_addr = req_addr;
            end
            if (mem_cnt > 0) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(mem_addr);
                end
            end
        end
    end

    // Memory model 2
    int          mem_lat2 = 1;
    int          mem_cnt2 = 0;
    logic [31:0] mem_addr2 = '0;
    logic        req_seen2 = 1'b0;
    logic [31:0] req_addr2 = '0;

    always @(negedge clk) begin
        req_seen2 = imem_req2 && !rst2;
        req_addr2 = imem_addr2;
    end

    always @(posedge clk) begin
        #1;
        imem_valid2 = 1'b0;
        if (rst2) begin
            mem_cnt2 = 0;
        end else begin
            if (req_seen2) begin
                mem_cnt2  = mem_lat2;
                mem_addr2 = req_addr2;
            end
            if (mem_cnt2 > 0) begin
                mem_cnt2 = mem_cnt2 - 1;
                if (mem_cnt2 == 0) begin
                    imem_valid2 = 1'b1;
                    imem_rdata2 = mem_word(mem_addr2);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] held_inst;
        logic [31:0] held_pc;
        int          iv_seen;

        rst            = 1'b1;
        rst2           = 1'b1;
        dec_ready      = 1'b0;
        dec_ready2     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        nxt();
        nxt();
        #1;
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);

        // Zero-wait run from reset
        rst = 1'b0;
        #1;
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        nxt(); #1;
        check("c1_busy", 32'(busy), 32'd1);
        check("c1_inst_valid", 32'(inst_valid), 32'd0);
        nxt(); #1;
        check("c2_inst_valid", 32'(inst_valid), 32'd1);
        check("c2_inst", inst, 32'h00A0_0093);
        check("c2_inst_pc", inst_pc, 32'h0);
        check("c2_opcode", 32'(inst_opcode), 32'h04);
        held_inst = inst;
        held_pc   = inst_pc;

        // Backpressure in HOLD
        for (int i = 0; i < 5; i++) begin
            nxt(); #1;
            check("bp_inst", inst, held_inst);
            check("bp_inst_pc", inst_pc, held_pc);
            check("bp_valid", 32'(inst_valid), 32'd1);
            check("bp_no_req", 32'(imem_req), 32'd0);
        end
        dec_ready = 1'b1;
        #1;
        nxt(); #1;
        check("seq_req4", 32'(imem_req), 32'd1);
        check("seq_addr4", imem_addr, 32'h4);
        nxt();
        nxt();
        nxt(); #1;
        check("thru_req8", 32'(imem_req), 32'd1);
        check("thru_addr8", imem_addr, 32'h8);
        dec_ready = 1'b0;
        mem_lat   = 3;

        // Redirect while waiting on a slow response
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        check("wr_no_req", 32'(imem_req), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        nxt();
        redirect_valid = 1'b0;
        #1;
        iv_seen = 0;
        for (int k = 0; k < 8 && !imem_req; k++) begin
            if (inst_valid) iv_seen = iv_seen + 1;
            nxt(); #1;
        end
        check("wr_stale_dropped", 32'(iv_seen), 32'd0);
        check("wr_req_seen", 32'(imem_req), 32'd1);
        check("wr_addr", imem_addr, 32'h0000_0100);
        mem_lat = 1;

        // Redirect coincident with the response
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        #1;
        nxt();
        redirect_valid = 1'b0;
        #1;
        check("rc_inst_valid", 32'(inst_valid), 32'd0);
        check("rc_req", 32'(imem_req), 32'd1);
        check("rc_addr", imem_addr, 32'h0000_0040);

        // Redirect in HOLD with dec_ready high
        nxt();
        nxt(); #1;
        check("rh_valid", 32'(inst_valid), 32'd1);
        check("rh_inst_pc", inst_pc, 32'h0000_0040);
        check("rh_inst", inst, mem_word(32'h40));
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        check("rh_no_req", 32'(imem_req), 32'd0);
        nxt();
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        #1;
        check("rh_valid_drop", 32'(inst_valid), 32'd0);
        check("rh_req", 32'(imem_req), 32'd1);
        check("rh_addr", imem_addr, 32'h0000_0200);
        nxt();
        nxt(); #1;
        check("rh2_inst_pc", inst_pc, 32'h0000_0200);
        dec_ready = 1'b1;
        #1;
        nxt();
        dec_ready = 1'b0;
        #1;
        check("rh2_req", 32'(imem_req), 32'd1);
        check("rh2_addr", imem_addr, 32'h0000_0204);

        // PC wrap and mid-WAIT reset on the second instance
        rst2 = 1'b0;
        #1;
        check("wrap_req0", 32'(imem_req2), 32'd1);
        check("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
        nxt();
        nxt(); #1;
        check("wrap_valid", 32'(inst_valid2), 32'd1);
        check("wrap_inst_pc", inst_pc2, 32'hFFFF_FFFC);
        check("wrap_inst", inst2, mem_word(32'hFFFF_FFFC));
        dec_ready2 = 1'b1;
        #1;
        nxt();
        dec_ready2 = 1'b0;
        mem_lat2   = 3;
        #1;
        check("wrap_req1", 32'(imem_req2), 32'd1);
        check("wrap_addr1", imem_addr2, 32'h0000_0000);
        nxt(); #1;
        check("mr_busy", 32'(busy2), 32'd1);
        rst2 = 1'b1;
        nxt(); #1;
        check("mr_valid", 32'(inst_valid2), 32'd0);
        check("mr_busy0", 32'(busy2), 32'd0);
        check("mr_req_in_rst", 32'(imem_req2), 32'd0);
        rst2 = 1'b0;
        #1;
        check("mr_req", 32'(imem_req2), 32'd1);
        check("mr_addr", imem_addr2, 32'hFFFF_FFFC);

        check("sb_pops", 32'(pops), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the main control decoder.
- Owns the PC and issues word reads to instruction memory, which may have variable latency. Holds the returned instruction until decode accepts it.
- Decode receives the instruction and its opcode field (inst[6:2]) for the control decoder.
- Accepts PC redirects from the branch-resolution logic (Branch AND Zero); wrong-path fetches are squashed.

Parameters:
- XLEN, 32, width of PC, addresses and instruction
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  one-cycle read request strobe
- imem_addr  out  XLEN  word address of request (bits[1:0]=00)
- imem_valid  in  1  read data valid; exactly one pulse per request, 1 or more cycles after imem_req
- imem_rdata  in  XLEN  instruction word, sampled when imem_valid=1
- inst_valid  out  1  inst/inst_pc/inst_opcode are valid
- dec_ready  in  1  decode accepts the instruction this cycle
- inst  out  XLEN  held instruction word
- inst_pc  out  XLEN  address of the held instruction
- inst_opcode  out  5  inst[6:2], fed to the control decoder
- redirect_valid  in  1  taken branch or jump; overrides sequential PC
- redirect_pc  in  XLEN  new PC; bits[1:0] ignored and forced to 00
- busy  out  1  a request is outstanding (state WAIT)

Behaviour:
- Reset (rst=1 at edge):
  - state=FETCH, pc=RESET_PC, discard=0
  - inst/inst_pc = 0, inst_valid=0, imem_req=0, busy=0
- Outputs are registered or decoded from state only:
  - imem_req is high only in FETCH with redirect_valid=0
  - imem_addr=pc whenever imem_req=1, else don't-care (drive pc)
  - inst_valid = (state==HOLD)
  - busy = (state==WAIT)
- Only one request is outstanding at a time.
- FETCH:
  - redirect_valid=0: assert imem_req with pc, go to WAIT.
  - redirect_valid=1: no request, pc<=redirect_pc, stay in FETCH.
- WAIT:
  - imem_valid=1, discard=0, redirect_valid=0: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4 (mod 2^XLEN, wraps silently), go to HOLD.
  - imem_valid=1 with discard=1 or redirect_valid=1: drop the data, clear discard, go to FETCH. If redirect_valid=1, pc<=redirect_pc.
  - imem_valid=0, redirect_valid=1: pc<=redirect_pc, discard<=1, stay in WAIT.
- HOLD:
  - inst, inst_pc and inst_opcode are stable while dec_ready=0.
  - dec_ready=1, redirect_valid=0: instruction is consumed, go to FETCH.
  - redirect_valid=1, regardless of dec_ready: squash the held instruction, pc<=redirect_pc, go to FETCH. No acceptance counts that cycle; decode must ignore it.
- Latency with a zero-wait memory (imem_valid one cycle after imem_req):
  - req@N, capture@N+1, inst_valid@N+2.
  - With dec_ready held high: one instruction per 3 cycles.
- Reset mid-operation: an outstanding response arriving after reset is not tracked. Memory is reset by the same rst, so no stray imem_valid arrives.
- An imem_valid received outside WAIT is ignored.

Decomposition:
- Shared package (pkg_rv_core):
  - fetch state enum FETCH/WAIT/HOLD
  - XLEN
  - RESET_PC default
  - OPCODE field slice constants (6:2)
  - PC_INC=4
- Sub-module pc_reg: PC register with reset value, sequential +4 and redirect mux.
- The FSM, discard flag and instruction register stay in instr_fetch_unit.
- RTL estimate: 150-220 lines.

Test Plan:
- Reset then run, zero-wait memory returning 32'h00A00093 at 0 -> imem_req@cycle0 addr=0; inst_valid@cycle2 with inst=32'h00A00093, inst_pc=0, inst_opcode=5'b00100; next imem_addr=4.
- Backpressure: dec_ready=0 for 5 cycles in HOLD -> inst/inst_pc unchanged, no imem_req; dec_ready=1 -> FETCH the next cycle with addr=pc+4.
- 3-cycle memory latency with redirect_valid=1, redirect_pc=32'h0000_0103 during WAIT -> stale response dropped, inst_valid stays 0; next imem_addr=32'h0000_0100.
- Redirect coincident with imem_valid in WAIT (redirect_pc=32'h40) -> data dropped; next request addr=32'h40.
- Redirect in HOLD with dec_ready=1 the same cycle -> inst_valid deasserts next cycle; next imem_addr=redirect_pc.
- PC wrap: RESET_PC=32'hFFFF_FFFC -> first inst_pc=32'hFFFF_FFFC; second request addr=32'h0000_0000; rst asserted mid-WAIT -> FETCH at RESET_PC next cycle with inst_valid=0.
